// File: rtl/weight_stream_receiver.sv
// -----------------------------------------------------------------------------
// weight_stream_receiver
//
// Receives a stream of weight words for a three-layer MLP and stores them in
// one RAM per layer: hidden1, hidden2 and output. A beat counter per layer and
// a sticky error flag decide whether the stream delivered a complete image.
// A read port with one cycle of latency can access any layer in every state.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   i_weight_valid      weight beat valid
//   i_weight_layer      target layer (01 hidden1, 10 hidden2, 11 output)
//   i_weight_addr       word address within the layer
//   i_weight            weight word
//   i_load_weight_done  end-of-stream pulse from the sender
//   i_rd_en             read request
//   i_rd_layer          layer to read
//   i_rd_addr           address to read
//   o_rd_valid          i_rd_en delayed by one cycle
//   o_rd_data           read data; 0 for an illegal read
//   o_load_done         level: a complete, error-free image is held
//   o_error             sticky protocol error for the current stream
//   o_busy              high while a stream is being received
// -----------------------------------------------------------------------------
module weight_stream_receiver #(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_INPUT_NODE          = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 24,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 24,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_weight_valid,
    input  logic [LAYER_WIDTH-1:0]          i_weight_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
    input  logic [DATA_WIDTH-1:0]           i_weight,
    input  logic                            i_load_weight_done,
    input  logic                            i_rd_en,
    input  logic [LAYER_WIDTH-1:0]          i_rd_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_rd_addr,
    output logic                            o_rd_valid,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic                            o_load_done,
    output logic                            o_error,
    output logic                            o_busy
);

    // Words per layer: every node has one weight per input plus a bias.
    localparam int S1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
    localparam int S2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
    localparam int S3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
    localparam int CW = 10;  // beat counter width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // Layer tag to size; tag 00 (and any unused tag) has size 0, so every
    // address compares out of range.
    function automatic logic [WEIGHT_COUNTER_WIDTH-1:0] layer_size(
        input logic [LAYER_WIDTH-1:0] layer
    );
        logic [WEIGHT_COUNTER_WIDTH-1:0] size;
        size = '0;
        if (layer == LAYER_WIDTH'(1)) size = WEIGHT_COUNTER_WIDTH'(S1);
        if (layer == LAYER_WIDTH'(2)) size = WEIGHT_COUNTER_WIDTH'(S2);
        if (layer == LAYER_WIDTH'(3)) size = WEIGHT_COUNTER_WIDTH'(S3);
        return size;
    endfunction

    state_t                     state_reg;
    logic [2:0][CW-1:0]         cnt_reg;
    logic                       error_reg;
    logic                       load_done_reg;
    logic                       busy_reg;
    logic                       rd_valid_reg;
    logic [LAYER_WIDTH-1:0]     rd_sel_reg;   // 0 marks an illegal read

    logic                       beat_legal;
    logic                       beat_illegal;
    logic                       rd_legal;
    logic [2:0]                 layer_hit;    // accepted beat for layer gi
    logic [2:0]                 rd_hit;
    logic [2:0]                 cnt_match;
    logic [2:0]                 cnt_ovf;      // accepted beat would pass S
    logic [2:0][CW-1:0]         cnt_next;     // counters after this beat
    logic [2:0][CW-1:0]         cnt_fresh;    // counters if this beat opens a new stream
    logic [2:0][DATA_WIDTH-1:0] ram_q;
    logic                       err_next;
    logic [DATA_WIDTH-1:0]      rd_data_mux;

    assign beat_legal   = (i_weight_layer != '0) && (i_weight_addr < layer_size(i_weight_layer));
    assign beat_illegal = i_weight_valid && !beat_legal;
    assign rd_legal     = (i_rd_layer != '0) && (i_rd_addr < layer_size(i_rd_layer));

    // Per-layer RAM, beat counter and bookkeeping.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_layer
            localparam int DEPTH = (gi == 0) ? S1 : ((gi == 1) ? S2 : S3);
            localparam int AW    = $clog2(DEPTH);
            localparam logic [CW-1:0] SZ = CW'(DEPTH);

            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] q_reg;

            assign layer_hit[gi] = i_weight_valid && beat_legal
                                   && (i_weight_layer == LAYER_WIDTH'(gi + 1));
            assign rd_hit[gi]    = i_rd_en && rd_legal
                                   && (i_rd_layer == LAYER_WIDTH'(gi + 1));

            // Read and write share one edge; the read sees the old word.
            always_ff @(posedge clk) begin
                if (layer_hit[gi]) begin
                    mem[i_weight_addr[AW-1:0]] <= i_weight;
                end
                if (rd_hit[gi]) begin
                    q_reg <= mem[i_rd_addr[AW-1:0]];
                end
            end

            assign ram_q[gi]     = q_reg;
            assign cnt_match[gi] = (cnt_reg[gi] == SZ);
            assign cnt_ovf[gi]   = layer_hit[gi] && (cnt_reg[gi] >= SZ);
            // Saturate at S+1 so an overrun stays visible as a mismatch.
            assign cnt_next[gi]  = (layer_hit[gi] && (cnt_reg[gi] != SZ + 1'b1))
                                   ? cnt_reg[gi] + 1'b1 : cnt_reg[gi];
            assign cnt_fresh[gi] = layer_hit[gi] ? CW'(1) : '0;
        end
    endgenerate

    assign err_next = error_reg || beat_illegal || (|cnt_ovf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            error_reg     <= 1'b0;
            load_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    cnt_reg   <= cnt_next;
                    error_reg <= err_next;
                    if (|layer_hit) begin
                        state_reg <= ST_RECV;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    // A beat coinciding with the done pulse is counted here,
                    // so CHECK sees it.
                    cnt_reg   <= cnt_next;
                    error_reg <= err_next;
                    if (i_load_weight_done) begin
                        state_reg <= ST_CHECK;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    cnt_reg   <= cnt_next;
                    error_reg <= err_next;
                    if ((&cnt_match) && !error_reg) begin
                        state_reg     <= ST_DONE;
                        load_done_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_FAIL;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    // The first beat after a finished stream opens a new one.
                    if (i_weight_valid) begin
                        state_reg     <= ST_RECV;
                        busy_reg      <= 1'b1;
                        load_done_reg <= 1'b0;
                        cnt_reg       <= cnt_fresh;
                        error_reg     <= beat_illegal;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Read port bookkeeping: the selected layer is registered alongside the
    // RAM output registers, and layer 0 forces a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
            rd_sel_reg   <= '0;
        end else begin
            rd_valid_reg <= i_rd_en;
            if (i_rd_en) begin
                rd_sel_reg <= rd_legal ? i_rd_layer : '0;
            end
        end
    end

    always_comb begin
        rd_data_mux = '0;
        for (int i = 0; i < 3; i++) begin
            if (rd_sel_reg == LAYER_WIDTH'(i + 1)) begin
                rd_data_mux = ram_q[i];
            end
        end
    end

    assign o_rd_valid  = rd_valid_reg;
    assign o_rd_data   = rd_data_mux;
    assign o_load_done = load_done_reg;
    assign o_error     = error_reg;
    assign o_busy      = busy_reg;

endmodule

// File: tb/tb_weight_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_weight_stream_receiver
//
// Directed bench for weight_stream_receiver. Inputs are driven 1 ns after the
// rising edge and outputs are checked at the same point, so each check sees
// the result of the edge just taken. Weight words follow the pattern
// 0xA000_0000 | layer<<16 | addr.
// -----------------------------------------------------------------------------
module tb_weight_stream_receiver;

    localparam int DW = 32;
    localparam int LW = 2;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_weight_valid;
    logic [LW-1:0] i_weight_layer;
    logic [AW-1:0] i_weight_addr;
    logic [DW-1:0] i_weight;
    logic          i_load_weight_done;
    logic          i_rd_en;
    logic [LW-1:0] i_rd_layer;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic          o_load_done;
    logic          o_error;
    logic          o_busy;

    always #5 clk = ~clk;

    weight_stream_receiver dut (
        .clk                (clk),
        .rst                (rst),
        .i_weight_valid     (i_weight_valid),
        .i_weight_layer     (i_weight_layer),
        .i_weight_addr      (i_weight_addr),
        .i_weight           (i_weight),
        .i_load_weight_done (i_load_weight_done),
        .i_rd_en            (i_rd_en),
        .i_rd_layer         (i_rd_layer),
        .i_rd_addr          (i_rd_addr),
        .o_rd_valid         (o_rd_valid),
        .o_rd_data          (o_rd_data),
        .o_load_done        (o_load_done),
        .o_error            (o_error),
        .o_busy             (o_busy)
    );

    typedef struct {
        logic [LW-1:0] layer;
        logic [AW-1:0] addr;
        logic [DW-1:0] exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab[10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int l, input int a);
        return 32'hA000_0000 | (32'(l) << 16) | 32'(a);
    endfunction

    task automatic beat(input int l, input int a, input logic [31:0] d);
        i_weight_valid = 1'b1;
        i_weight_layer = LW'(l);
        i_weight_addr  = AW'(a);
        i_weight       = d;
        tick();
        i_weight_valid = 1'b0;
    endtask

    // Full ordered stream; optionally omits layer 3 address 74.
    task automatic stream(input bit skip_last);
        int sizes[3] = '{72, 600, 75};
        for (int l = 1; l <= 3; l++) begin
            for (int a = 0; a < sizes[l-1]; a++) begin
                if (!(skip_last && l == 3 && a == 74)) beat(l, a, pat(l, a));
            end
        end
    endtask

    // Done pulse; o_load_done can only rise on the second edge.
    task automatic done_pulse();
        i_load_weight_done = 1'b1;
        tick();
        i_load_weight_done = 1'b0;
        chk("load_done_low_in_check", 32'(o_load_done), 32'd0);
        tick();
    endtask

    task automatic rd(input int l, input int a);
        i_rd_en    = 1'b1;
        i_rd_layer = LW'(l);
        i_rd_addr  = AW'(a);
        tick();
        i_rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rd_tab[0] = '{2'd1, 11'd0,    32'hA001_0000};
        rd_tab[1] = '{2'd1, 11'd71,   32'hA001_0047};
        rd_tab[2] = '{2'd2, 11'd0,    32'hA002_0000};
        rd_tab[3] = '{2'd2, 11'd599,  32'hA002_0257};
        rd_tab[4] = '{2'd3, 11'd74,   32'hA003_004A};
        rd_tab[5] = '{2'd0, 11'd5,    32'h0000_0000};
        rd_tab[6] = '{2'd1, 11'd72,   32'h0000_0000};
        rd_tab[7] = '{2'd2, 11'd600,  32'h0000_0000};
        rd_tab[8] = '{2'd3, 11'd75,   32'h0000_0000};
        rd_tab[9] = '{2'd3, 11'd2047, 32'h0000_0000};

        rst = 1'b1;
        i_weight_valid = 1'b0;
        i_weight_layer = '0;
        i_weight_addr = '0;
        i_weight = '0;
        i_load_weight_done = 1'b0;
        i_rd_en = 1'b0;
        i_rd_layer = '0;
        i_rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        chk("reset_load_done", 32'(o_load_done), 32'd0);
        chk("reset_error", 32'(o_error), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("reset_rd_data", o_rd_data, 32'd0);

        // Full ordered stream reaches DONE.
        stream(1'b0);
        chk("full_busy_in_recv", 32'(o_busy), 32'd1);
        done_pulse();
        chk("full_load_done", 32'(o_load_done), 32'd1);
        chk("full_error", 32'(o_error), 32'd0);
        chk("full_busy_after", 32'(o_busy), 32'd0);
        rd(2, 599);
        chk("rd_l2_599_valid", 32'(o_rd_valid), 32'd1);
        chk("rd_l2_599_data", o_rd_data, 32'hA002_0257);
        tick();
        chk("rd_valid_drops", 32'(o_rd_valid), 32'd0);

        // Read table, legal and illegal addresses.
        for (int i = 0; i < 10; i++) begin
            rd(int'(rd_tab[i].layer), int'(rd_tab[i].addr));
            chk($sformatf("tab%0d_valid", i), 32'(o_rd_valid), 32'd1);
            chk($sformatf("tab%0d_data", i), o_rd_data, rd_tab[i].exp_data);
        end
        chk("tab_no_error", 32'(o_error), 32'd0);

        // New beat after DONE opens a new stream.
        beat(1, 0, pat(1, 0));
        chk("restart_load_done", 32'(o_load_done), 32'd0);
        chk("restart_busy", 32'(o_busy), 32'd1);
        chk("restart_cnt_l1", 32'(dut.cnt_reg[0]), 32'd1);
        chk("restart_cnt_l2", 32'(dut.cnt_reg[1]), 32'd0);

        // Missing last word -> FAIL without error; RAM survives reset.
        do_reset();
        stream(1'b1);
        done_pulse();
        chk("missing_load_done", 32'(o_load_done), 32'd0);
        chk("missing_error", 32'(o_error), 32'd0);
        chk("missing_busy", 32'(o_busy), 32'd0);
        rd(3, 74);
        chk("ram_kept_over_reset", o_rd_data, 32'hA003_004A);

        // Illegal beats are dropped and make the next stream FAIL.
        do_reset();
        beat(0, 5, 32'hDEAD_BEEF);
        chk("illegal_l0_error", 32'(o_error), 32'd1);
        beat(1, 72, 32'hDEAD_BEEF);
        chk("illegal_range_error", 32'(o_error), 32'd1);
        rd(1, 5);
        chk("illegal_ram_l1_5", o_rd_data, 32'hA001_0005);
        rd(1, 71);
        chk("illegal_ram_l1_71", o_rd_data, 32'hA001_0047);
        stream(1'b0);
        done_pulse();
        chk("illegal_load_done", 32'(o_load_done), 32'd0);
        chk("illegal_error_sticky", 32'(o_error), 32'd1);

        // Read-before-write on the same word.
        do_reset();
        beat(1, 3, 32'h3F80_0000);
        i_weight_valid = 1'b1;
        i_weight_layer = 2'd1;
        i_weight_addr  = 11'd3;
        i_weight       = 32'h4000_0000;
        i_rd_en        = 1'b1;
        i_rd_layer     = 2'd1;
        i_rd_addr      = 11'd3;
        tick();
        i_weight_valid = 1'b0;
        i_rd_en        = 1'b0;
        chk("rbw_old_word", o_rd_data, 32'h3F80_0000);
        rd(1, 3);
        chk("rbw_new_word", o_rd_data, 32'h4000_0000);

        // Reset mid-stream after 300 beats.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if (n < 72) beat(1, n, pat(1, n));
            else beat(2, n - 72, pat(2, n - 72));
        end
        rd(2, 10);
        chk("mid_rd_before_rst", o_rd_data, 32'hA002_000A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_error", 32'(o_error), 32'd0);
        chk("mid_rst_load_done", 32'(o_load_done), 32'd0);
        chk("mid_rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("mid_rst_rd_data", o_rd_data, 32'd0);
        stream(1'b0);
        done_pulse();
        chk("after_rst_load_done", 32'(o_load_done), 32'd1);
        chk("after_rst_error", 32'(o_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
